// File: rtl/eic_ahb_slave_pkg.sv
// ----------------------------------------------------------------------------
// eic_ahb_slave_pkg : shared constants for the eic AHB-Lite front end
//                     (register index width, HTRANS codes, HSIZE word code).
// Revision: 1.1
// ----------------------------------------------------------------------------
`default_nettype none

package eic_ahb_slave_pkg;

    localparam int EIC_ADDR_W = 4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    function automatic logic is_legal_xfer(input logic [2:0] size, input logic [1:0] addr_lo);
        return (size == HSIZE_WORD) && (addr_lo == 2'b00);
    endfunction

endpackage

`default_nettype wire

// File: rtl/eic_ahb_slave.sv
// ----------------------------------------------------------------------------
// eic_ahb_slave : AHB-Lite word-only slave front end for the eic register file.
// Optional: EIC_AHB_SLAVE_RDWAIT_EN adds one wait state to reads (registered HRDATA).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module eic_ahb_slave
  import eic_ahb_slave_pkg::*;
#(
  parameter int ADDR_W = EIC_ADDR_W
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [31:0]       HADDR,
  input  logic [2:0]        HBURST,
  input  logic              HSEL,
  input  logic [2:0]        HSIZE,
  input  logic [1:0]        HTRANS,
  input  logic [31:0]       HWDATA,
  input  logic              HWRITE,
  output logic [31:0]       HRDATA,
  output logic              HREADY,
  output logic              HRESP,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [31:0]       read_data,
  output logic [ADDR_W-1:0] write_addr,
  output logic [31:0]       write_data,
  output logic              write_enable
);

`ifdef EIC_AHB_SLAVE_RDWAIT_EN
  typedef enum logic [2:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2, ST_RDW} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ERR1, ST_ERR2} state_e;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              write_q, write_d;
  logic              accept;
  logic              legal;
  logic [31:0]       rdata_src;
  logic              unused_bits;

  // Only the index bits, the alignment bits and HTRANS matter; the rest is ignored.
  assign unused_bits = ^{HBURST, HADDR[31:ADDR_W+2]};

  assign accept = HSEL && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ)) && HREADY;
  assign legal  = is_legal_xfer(HSIZE, HADDR[1:0]);

  assign read_addr  = idx_q;
  assign write_addr = idx_q;

`ifdef EIC_AHB_SLAVE_RDWAIT_EN
  logic [31:0] hrdata_q, hrdata_d;

  assign hrdata_d  = (state_q == ST_RDW) ? read_data : hrdata_q;
  assign rdata_src = hrdata_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) hrdata_q <= 32'd0;
    else          hrdata_q <= hrdata_d;
  end
`else
  assign rdata_src = read_data;
`endif

  always_comb begin
    HREADY       = 1'b1;
    HRESP        = 1'b0;
    HRDATA       = 32'd0;
    write_enable = 1'b0;
    write_data   = 32'd0;
    case (state_q)
      ST_DATA: begin
        if (write_q) begin
          write_enable = 1'b1;
          write_data   = HWDATA;
        end else begin
          HRDATA = rdata_src;
        end
      end
      ST_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      ST_ERR2: HRESP = 1'b1;
`ifdef EIC_AHB_SLAVE_RDWAIT_EN
      ST_RDW:  HREADY = 1'b0;
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d = ST_IDLE;
    idx_d   = idx_q;
    write_d = write_q;
    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
`ifdef EIC_AHB_SLAVE_RDWAIT_EN
    end else if (state_q == ST_RDW) begin
      state_d = ST_DATA;
`endif
    end else if (accept) begin
      idx_d   = HADDR[ADDR_W+1:2];
      write_d = HWRITE;
      if (!legal) begin
        state_d = ST_ERR1;
`ifdef EIC_AHB_SLAVE_RDWAIT_EN
      end else if (!HWRITE) begin
        state_d = ST_RDW;
`endif
      end else begin
        state_d = ST_DATA;
      end
    end
  end

  // Asynchronous reset also kills write_enable mid data phase, dropping the write.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      write_q <= write_d;
    end
  end

endmodule

`default_nettype wire
